// File: rtl/qpsk_symbol_gen.sv
// Framed QPSK impulse source: alternating preamble followed by a PRBS-9 payload.
// Emits one Gray-mapped +/-AMP symbol every SYM_DIV clocks and zeros in between.
module qpsk_symbol_gen #(
    parameter int SYM_DIV = 8,
    parameter int PRE_LEN = 16,
    parameter int PAY_LEN = 112,
    parameter int W       = 14,
    parameter int AMP     = 4096
) (
    input  logic                clock_5000,
    input  logic                reset,
    input  logic                enable,
    output logic signed [W-1:0] sym_i,
    output logic signed [W-1:0] sym_q,
    output logic                sym_strobe,
    output logic                frame_start,
    output logic                busy
);
    localparam int PH_W  = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam int CNT_W = 12;

    localparam logic [PH_W-1:0]     PH_LAST   = PH_W'(SYM_DIV - 1);
    localparam logic [CNT_W-1:0]    PRE_LAST  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0]    PAY_LAST  = CNT_W'(PAY_LEN - 1);
    localparam logic signed [W-1:0] POS_AMP   = W'(AMP);
    localparam logic signed [W-1:0] NEG_AMP   = -POS_AMP;
    localparam logic [8:0]          PRBS_SEED = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2
    } state_t;

    function automatic logic [8:0] prbs_step(input logic [8:0] s);
        return {s[7:0], s[8] ^ s[4]};
    endfunction

    function automatic logic signed [W-1:0] map_bit(input logic b);
        return b ? NEG_AMP : POS_AMP;
    endfunction

    state_t              state_r;
    state_t              next_state_s;
    logic [PH_W-1:0]     phase_r;
    logic [CNT_W-1:0]    sym_cnt_r;
    logic [8:0]          prbs_r;
    logic [8:0]          prbs_one_s;
    logic [8:0]          prbs_two_s;
    logic                emit_s;
    logic                switch_s;
    logic signed [W-1:0] sym_i_s;
    logic signed [W-1:0] sym_q_s;
    logic                strobe_s;
    logic                frame_start_s;
    logic                busy_s;

    assign prbs_one_s = prbs_step(prbs_r);
    assign prbs_two_s = prbs_step(prbs_one_s);
    // A symbol goes out only while running, still enabled, at phase zero.
    assign emit_s     = (state_r != IDLE) && enable && (phase_r == '0);
    assign switch_s   = emit_s && (next_state_s != state_r);

    // State register.
    always_ff @(posedge clock_5000) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; dropping enable always returns to IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) next_state_s = PREAMBLE;
                else        next_state_s = IDLE;
            end
            PREAMBLE: begin
                if (!enable)                                     next_state_s = IDLE;
                else if (phase_r == '0 && sym_cnt_r == PRE_LAST) next_state_s = PAYLOAD;
                else                                             next_state_s = PREAMBLE;
            end
            PAYLOAD: begin
                if (!enable)                                     next_state_s = IDLE;
                else if (phase_r == '0 && sym_cnt_r == PAY_LAST) next_state_s = PREAMBLE;
                else                                             next_state_s = PAYLOAD;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode, registered below so enable never reaches a port combinationally.
    always_comb begin
        sym_i_s       = '0;
        sym_q_s       = '0;
        strobe_s      = 1'b0;
        frame_start_s = 1'b0;
        busy_s        = (next_state_s != IDLE);
        if (emit_s) begin
            strobe_s = 1'b1;
            if (state_r == PREAMBLE) begin
                frame_start_s = (sym_cnt_r == '0);
                sym_i_s       = map_bit(sym_cnt_r[0]);
                sym_q_s       = map_bit(sym_cnt_r[0]);
            end else begin
                frame_start_s = 1'b0;
                sym_i_s       = map_bit(prbs_r[8]);
                sym_q_s       = map_bit(prbs_one_s[8]);
            end
        end else begin
            strobe_s      = 1'b0;
            frame_start_s = 1'b0;
        end
    end

    // Counters, scrambler and output registers.
    always_ff @(posedge clock_5000) begin
        if (reset) begin
            phase_r     <= '0;
            sym_cnt_r   <= '0;
            prbs_r      <= PRBS_SEED;
            sym_i       <= '0;
            sym_q       <= '0;
            sym_strobe  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sym_i       <= sym_i_s;
            sym_q       <= sym_q_s;
            sym_strobe  <= strobe_s;
            frame_start <= frame_start_s;
            busy        <= busy_s;
            if (state_r == IDLE || next_state_s == IDLE) begin
                phase_r   <= '0;
                sym_cnt_r <= '0;
                prbs_r    <= PRBS_SEED;
            end else begin
                phase_r <= (phase_r == PH_LAST) ? '0 : phase_r + 1'b1;
                if (switch_s)    sym_cnt_r <= '0;
                else if (emit_s) sym_cnt_r <= sym_cnt_r + 1'b1;
                else             sym_cnt_r <= sym_cnt_r;
                // Reseeding at each frame wrap makes every payload identical.
                if (switch_s && state_r == PAYLOAD)     prbs_r <= PRBS_SEED;
                else if (emit_s && state_r == PAYLOAD) prbs_r <= prbs_two_s;
                else                                    prbs_r <= prbs_r;
            end
        end
    end

endmodule

// File: tb/tb_qpsk_symbol_gen.sv
// Directed bench for qpsk_symbol_gen: default build plus a minimal-length,
// full-scale build (SYM_DIV=2, PRE_LEN=1, PAY_LEN=1, AMP=8191).
module tb_qpsk_symbol_gen;
    localparam int SD    = 8;
    localparam int PRE   = 16;
    localparam int PAY   = 112;
    localparam int FRAME = PRE + PAY;

    localparam logic signed [13:0] P_A = 14'sd4096;
    localparam logic signed [13:0] N_A = -14'sd4096;
    localparam logic signed [13:0] P_B = 14'sd8191;
    localparam logic signed [13:0] N_B = -14'sd8191;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic               reset, enable, sym_strobe, frame_start, busy;
    logic signed [13:0] sym_i, sym_q;
    logic               reset2, enable2, sym_strobe2, frame_start2, busy2;
    logic signed [13:0] sym_i2, sym_q2;

    int n_cmp = 0;
    int n_bad = 0;

    qpsk_symbol_gen dut (
        .clock_5000(clk), .reset(reset), .enable(enable),
        .sym_i(sym_i), .sym_q(sym_q), .sym_strobe(sym_strobe),
        .frame_start(frame_start), .busy(busy)
    );

    qpsk_symbol_gen #(.SYM_DIV(2), .PRE_LEN(1), .PAY_LEN(1), .W(14), .AMP(8191)) dut2 (
        .clock_5000(clk), .reset(reset2), .enable(enable2),
        .sym_i(sym_i2), .sym_q(sym_q2), .sym_strobe(sym_strobe2),
        .frame_start(frame_start2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] prbs_next(input logic [8:0] s);
        return {s[7:0], s[8] ^ s[4]};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({busy, sym_strobe, frame_start} !== 3'b000 || sym_i !== 14'sd0 || sym_q !== 14'sd0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b strobe=%b fs=%b i=%0d q=%0d, required all 0",
                     busy, sym_strobe, frame_start, sym_i, sym_q);
        end
        enable = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if ({busy, sym_strobe, frame_start} !== 3'b000 || sym_i !== 14'sd0 || sym_q !== 14'sd0) begin
                n_bad++;
                $display("FAIL idle_hold cycle %0d: busy=%b strobe=%b i=%0d, required idle zeros",
                         c, busy, sym_strobe, sym_i);
            end
        end
    endtask

    task automatic test_start();
        enable = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b1 || sym_strobe !== 1'b0) begin
            n_bad++;
            $display("FAIL start_busy: busy=%b strobe=%b, required busy=1 strobe=0", busy, sym_strobe);
        end
    endtask

    // Two full frames plus one symbol against an independent frame/PRBS model.
    task automatic test_frames();
        logic [8:0]         s;
        logic signed [13:0] ei, eq;
        logic               es, ef;
        int                 k;
        s = 9'h1FF;
        for (int t = 0; t < 2 * FRAME * SD + SD; t++) begin
            tick();
            ei = 14'sd0; eq = 14'sd0; es = 1'b0; ef = 1'b0;
            if (t % SD == 0) begin
                k  = (t / SD) % FRAME;
                es = 1'b1;
                ef = (k == 0);
                if (k == 0) s = 9'h1FF;
                if (k < PRE) begin
                    ei = (k % 2 == 1) ? N_A : P_A;
                    eq = ei;
                end else begin
                    ei = s[8] ? N_A : P_A;
                    s  = prbs_next(s);
                    eq = s[8] ? N_A : P_A;
                    s  = prbs_next(s);
                end
            end
            n_cmp++;
            if ({busy, sym_strobe, frame_start, sym_i, sym_q} !== {1'b1, es, ef, ei, eq}) begin
                n_bad++;
                $display("FAIL frame t=%0d: busy=%b strobe=%b fs=%b i=%0d q=%0d, required busy=1 strobe=%b fs=%b i=%0d q=%0d",
                         t, busy, sym_strobe, frame_start, sym_i, sym_q, es, ef, ei, eq);
            end
            if (t % SD == 0 && (t / SD) >= PRE && (t / SD) < PRE + 4) begin
                n_cmp++;
                if (sym_i !== N_A || sym_q !== N_A) begin
                    n_bad++;
                    $display("FAIL payload_seed sym %0d: i=%0d q=%0d, required -4096 -4096",
                             t / SD - PRE, sym_i, sym_q);
                end
            end
            if (t == (PRE + 4) * SD) begin
                n_cmp++;
                if (sym_i !== N_A || sym_q !== P_A) begin
                    n_bad++;
                    $display("FAIL payload_fb: i=%0d q=%0d, required -4096 +4096", sym_i, sym_q);
                end
            end
            if (t == FRAME * SD) begin
                n_cmp++;
                if (frame_start !== 1'b1 || sym_i !== P_A || sym_q !== P_A) begin
                    n_bad++;
                    $display("FAIL frame_wrap: fs=%b i=%0d q=%0d, required fs=1 +4096 +4096",
                             frame_start, sym_i, sym_q);
                end
            end
        end
    endtask

    // Drop enable so that the sampling edge is exactly a strobe edge.
    task automatic test_disable_on_strobe();
        int cyc;
        cyc = 0;
        while (sym_strobe !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (sym_strobe !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_strobe: strobe=%b after %0d cycles, required 1", sym_strobe, cyc);
        end
        repeat (SD - 1) tick();
        enable = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if ({busy, sym_strobe, frame_start} !== 3'b000 || sym_i !== 14'sd0 || sym_q !== 14'sd0) begin
                n_bad++;
                $display("FAIL disable_on_strobe +%0d: busy=%b strobe=%b i=%0d q=%0d, required all 0",
                         c, busy, sym_strobe, sym_i, sym_q);
            end
        end
    endtask

    task automatic test_enable_drop();
        int idx, cyc;
        enable = 1'b1;
        tick();
        idx = -1;
        cyc = 0;
        while (idx < 40 && cyc < 400) begin
            tick();
            cyc++;
            if (sym_strobe === 1'b1) idx++;
        end
        n_cmp++;
        if (idx != 40) begin
            n_bad++;
            $display("FAIL wait_strobe40: reached index %0d, required 40", idx);
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if ({busy, sym_strobe, frame_start} !== 3'b000 || sym_i !== 14'sd0 || sym_q !== 14'sd0) begin
            n_bad++;
            $display("FAIL drop_idle: busy=%b strobe=%b i=%0d q=%0d, required all 0", busy, sym_strobe, sym_i, sym_q);
        end
        enable = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b1 || sym_strobe !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_rebusy: busy=%b strobe=%b, required busy=1 strobe=0", busy, sym_strobe);
        end
        tick();
        n_cmp++;
        if (sym_strobe !== 1'b1 || frame_start !== 1'b1 || sym_i !== P_A || sym_q !== P_A) begin
            n_bad++;
            $display("FAIL drop_restart: strobe=%b fs=%b i=%0d q=%0d, required 1 1 +4096 +4096",
                     sym_strobe, frame_start, sym_i, sym_q);
        end
        for (int j = 1; j <= PRE + 4; j++) begin
            repeat (SD) tick();
            if (j >= PRE) begin
                n_cmp++;
                if (sym_strobe !== 1'b1 || sym_i !== N_A || sym_q !== ((j == PRE + 4) ? P_A : N_A)) begin
                    n_bad++;
                    $display("FAIL drop_reseed sym %0d: strobe=%b i=%0d q=%0d, required 1 -4096 %0d",
                             j, sym_strobe, sym_i, sym_q, (j == PRE + 4) ? P_A : N_A);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (13) tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({busy, sym_strobe, frame_start} !== 3'b000 || sym_i !== 14'sd0 || sym_q !== 14'sd0) begin
            n_bad++;
            $display("FAIL reset_mid: busy=%b strobe=%b i=%0d q=%0d, required all 0", busy, sym_strobe, sym_i, sym_q);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b1 || sym_strobe !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rebusy: busy=%b strobe=%b, required busy=1 strobe=0", busy, sym_strobe);
        end
        tick();
        n_cmp++;
        if (sym_strobe !== 1'b1 || frame_start !== 1'b1 || sym_i !== P_A || sym_q !== P_A) begin
            n_bad++;
            $display("FAIL reset_restart: strobe=%b fs=%b i=%0d q=%0d, required 1 1 +4096 +4096",
                     sym_strobe, frame_start, sym_i, sym_q);
        end
        repeat (SD) tick();
        n_cmp++;
        if (sym_strobe !== 1'b1 || frame_start !== 1'b0 || sym_i !== N_A || sym_q !== N_A) begin
            n_bad++;
            $display("FAIL reset_sym1: strobe=%b fs=%b i=%0d q=%0d, required 1 0 -4096 -4096",
                     sym_strobe, frame_start, sym_i, sym_q);
        end
    endtask

    // Single-symbol preamble and payload at two samples per symbol, full-scale amplitude.
    task automatic test_sweep();
        logic signed [13:0] ev;
        logic               es, ef;
        tick();
        n_cmp++;
        if ({busy2, sym_strobe2, frame_start2} !== 3'b000 || sym_i2 !== 14'sd0 || sym_q2 !== 14'sd0) begin
            n_bad++;
            $display("FAIL sweep_reset: busy=%b strobe=%b i=%0d, required all 0", busy2, sym_strobe2, sym_i2);
        end
        reset2 = 1'b0;
        enable2 = 1'b1;
        tick();
        n_cmp++;
        if (busy2 !== 1'b1 || sym_strobe2 !== 1'b0) begin
            n_bad++;
            $display("FAIL sweep_busy: busy=%b strobe=%b, required busy=1 strobe=0", busy2, sym_strobe2);
        end
        for (int t = 0; t < 16; t++) begin
            tick();
            es = (t % 2 == 0);
            ef = (t % 4 == 0);
            ev = (t % 2 == 1) ? 14'sd0 : ((t % 4 == 0) ? P_B : N_B);
            n_cmp++;
            if ({busy2, sym_strobe2, frame_start2, sym_i2, sym_q2} !== {1'b1, es, ef, ev, ev}) begin
                n_bad++;
                $display("FAIL sweep t=%0d: busy=%b strobe=%b fs=%b i=%0d q=%0d, required busy=1 strobe=%b fs=%b i=q=%0d",
                         t, busy2, sym_strobe2, frame_start2, sym_i2, sym_q2, es, ef, ev);
            end
        end
        enable2 = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        reset2  = 1'b1;
        enable2 = 1'b0;
        test_reset();
        test_start();
        test_frames();
        test_disable_on_strobe();
        test_enable_drop();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
